// File: rtl/data_ram_pipe.sv
// rtl/data_ram_pipe.sv - byte-lane data memory with request/response handshake and power-up clear
//
// Purpose: MEM-stage data memory of 2^DEPTH_LOG2 words of DATA_WIDTH bits, byte-lane writes,
//          masked registered reads, out-of-range error reporting and an optional clear-after-reset.
// Ports:
//   clock, reset              single clock; asynchronous active-high reset
//   req_valid/req_ready       request handshake (req_ready is RUN && response slot free)
//   req_write                 1 = store, 0 = load
//   req_address               byte address, low BYTE_OFS bits ignored
//   req_sel                   byte-lane enables
//   req_data                  store data
//   resp_valid/resp_ready     response handshake
//   resp_data                 masked load data, 0 for stores and errors
//   resp_error                address out of range
//   init_done                 clear sequence finished, block operational
module data_ram_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH_LOG2     = 10,
  parameter int ADDR_WIDTH     = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_address,
  input  logic [DATA_WIDTH/8-1:0] req_sel,
  input  logic [DATA_WIDTH-1:0]   req_data,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    resp_error,
  output logic                    init_done
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int BYTE_OFS = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int DEPTH    = 1 << DEPTH_LOG2;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [0:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

  localparam logic [DEPTH_LOG2-1:0] IDX_ONE  = 1;
  localparam logic [DEPTH_LOG2-1:0] IDX_LAST = '1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [0:0]            state_q, state_d;
  logic [DEPTH_LOG2-1:0] clear_idx_q, clear_idx_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_error_q, resp_error_d;

  logic [DEPTH_LOG2-1:0] idx;
  logic                  oor;
  logic                  accept;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_masked;
  logic                  unused_addr;

  assign idx = req_address[DEPTH_LOG2+BYTE_OFS-1:BYTE_OFS];
  // Any address bit above the word index makes the request out of range.
  assign oor = (req_address >> (DEPTH_LOG2 + BYTE_OFS)) != '0;
  // Byte-offset bits take no part in the access.
  assign unused_addr = ^req_address;

  assign req_ready  = (state_q == ST_RUN) && (!resp_valid_q || resp_ready);
  assign accept     = req_valid && req_ready;
  assign init_done  = (state_q == ST_RUN);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_error = resp_error_q;

  assign rd_word = mem_q[idx];

  always_comb begin
    rd_masked = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (req_sel[i]) rd_masked[8*i +: 8] = rd_word[8*i +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    if (state_q == ST_INIT) begin
      clear_idx_d = clear_idx_q + IDX_ONE;
      if (clear_idx_q == IDX_LAST) state_d = ST_RUN;
    end
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_error_d = resp_error_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_error_d = oor;
      resp_data_d  = (!req_write && !oor) ? rd_masked : '0;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RESET;
      clear_idx_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_idx_q  <= clear_idx_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
    end
  end

  // Storage has no reset; the INIT sweep provides the zeroing when enabled.
  always_ff @(posedge clock) begin
    if (state_q == ST_INIT) begin
      mem_q[clear_idx_q] <= '0;
    end else if (accept && req_write && !oor) begin
      for (int i = 0; i < BYTES; i++) begin
        if (req_sel[i]) mem_q[idx][8*i +: 8] <= req_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_ram_pipe.sv
// tb/tb_data_ram_pipe.sv - directed table-driven bench for data_ram_pipe
module tb_data_ram_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_address;
  logic [3:0]  req_sel;
  logic [31:0] req_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_error;
  logic        init_done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  data_ram_pipe #(
    .DATA_WIDTH(32), .DEPTH_LOG2(4), .ADDR_WIDTH(32), .CLEAR_ON_RESET(1)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_sel(req_sel), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_error(resp_error), .init_done(init_done)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vt[15];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Counts cycles from reset release until init_done, noting any early req_ready.
  task automatic wait_init(input string nm);
    int n;
    int early;
    n = 0;
    early = 0;
    while (init_done !== 1'b1 && n < 200) begin
      if (req_ready !== 1'b0) early++;
      tick();
      n++;
    end
    check({nm, "_init_cycles"}, n, 16);
    check({nm, "_ready_during_init"}, early, 0);
    check({nm, "_ready_after_init"}, {31'b0, req_ready}, 1);
  endtask

  // Issue one request and check the response one cycle later.
  task automatic do_req(input string nm, input logic wr, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] data,
                        input logic [31:0] exp_data, input logic exp_err);
    req_valid   = 1'b1;
    req_write   = wr;
    req_address = addr;
    req_sel     = sel;
    req_data    = data;
    tick();
    req_valid = 1'b0;
    check({nm, "_valid"}, {31'b0, resp_valid}, 1);
    check({nm, "_data"}, resp_data, exp_data);
    check({nm, "_err"}, {31'b0, resp_error}, {31'b0, exp_err});
  endtask

  initial begin
    vt[0]  = '{1'b1, 32'h8,    4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 32'h8,    4'hF, 32'h0,        32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h8,    4'h5, 32'h11223344, 32'h0,        1'b0};
    vt[3]  = '{1'b0, 32'h8,    4'hF, 32'h0,        32'hDE22BE44, 1'b0};
    vt[4]  = '{1'b0, 32'h8,    4'h3, 32'h0,        32'h0000BE44, 1'b0};
    vt[5]  = '{1'b0, 32'h8,    4'h0, 32'h0,        32'h0,        1'b0};
    vt[6]  = '{1'b1, 32'h8,    4'h0, 32'hAABBCCDD, 32'h0,        1'b0};
    vt[7]  = '{1'b0, 32'hA,    4'hF, 32'h0,        32'hDE22BE44, 1'b0};
    vt[8]  = '{1'b1, 32'h3C,   4'hF, 32'h12345678, 32'h0,        1'b0};
    vt[9]  = '{1'b0, 32'h3F,   4'hA, 32'h0,        32'h12005600, 1'b0};
    vt[10] = '{1'b1, 32'h40,   4'hF, 32'hFFFFFFFF, 32'h0,        1'b1};
    vt[11] = '{1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, 32'h0,        1'b1};
    vt[12] = '{1'b0, 32'h1000, 4'hF, 32'h0,        32'h0,        1'b1};
    vt[13] = '{1'b0, 32'h0,    4'hF, 32'h0,        32'h0,        1'b0};
    vt[14] = '{1'b0, 32'h4,    4'h8, 32'h0,        32'h0,        1'b0};

    reset       = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_address = '0;
    req_sel     = '0;
    req_data    = '0;
    resp_ready  = 1'b1;
    tick();
    tick();
    check("rst_resp_valid", {31'b0, resp_valid}, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_error", {31'b0, resp_error}, 0);
    check("rst_req_ready", {31'b0, req_ready}, 0);
    check("rst_init_done", {31'b0, init_done}, 0);
    reset = 1'b0;
    wait_init("boot");

    for (int w = 0; w < 16; w++) begin
      do_req($sformatf("clear_w%0d", w), 1'b0, 32'(w * 4), 4'hF, 32'h0, 32'h0, 1'b0);
    end

    for (int i = 0; i < 15; i++) begin
      check($sformatf("vec%0d_ready", i), {31'b0, req_ready}, 1);
      do_req($sformatf("vec%0d", i), vt[i].wr, vt[i].addr, vt[i].sel, vt[i].data,
             vt[i].exp_data, vt[i].exp_err);
    end

    // Backpressure: hold the consumer off for three cycles with a second load waiting.
    tick();
    resp_ready  = 1'b0;
    req_valid   = 1'b1;
    req_write   = 1'b0;
    req_address = 32'h8;
    req_sel     = 4'hF;
    tick();
    req_address = 32'h3C;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp%0d_valid", c), {31'b0, resp_valid}, 1);
      check($sformatf("bp%0d_data", c), resp_data, 32'hDE22BE44);
      check($sformatf("bp%0d_ready", c), {31'b0, req_ready}, 0);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'b0, req_ready}, 1);
    tick();
    req_valid = 1'b0;
    check("bp_second_valid", {31'b0, resp_valid}, 1);
    check("bp_second_data", resp_data, 32'h12345678);
    tick();
    check("bp_drained", {31'b0, resp_valid}, 0);

    // Reset in the middle of streaming loads.
    req_valid   = 1'b1;
    req_address = 32'h8;
    tick();
    tick();
    check("mid_stream_valid", {31'b0, resp_valid}, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", {31'b0, resp_valid}, 0);
    check("mid_rst_ready", {31'b0, req_ready}, 0);
    check("mid_rst_init", {31'b0, init_done}, 0);
    req_valid = 1'b0;
    tick();
    reset = 1'b0;
    wait_init("rerun");
    do_req("reclear_w2", 1'b0, 32'h8, 4'hF, 32'h0, 32'h0, 1'b0);
    do_req("reclear_w15", 1'b0, 32'h3C, 4'hF, 32'h0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
